// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO between the MMIO write port and the UART transmitter.
// First-word-fall-through: the head entry is always visible on deq_data while deq_valid is high.
module uart_tx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_BITS  = $clog2(DEPTH),
    parameter int COUNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      enq_data,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    output logic [WIDTH-1:0]      deq_data,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [COUNT_BITS-1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow
);

    localparam logic [COUNT_BITS-1:0] COUNT_MAX = COUNT_BITS'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [COUNT_BITS-1:0] count_q;
    logic                  overflow_q;

    logic enq_fire;
    logic deq_fire;
    logic write_en;

    // Status comes from the count register only, so no input reaches an output combinationally.
    assign full      = (count_q == COUNT_MAX);
    assign empty     = (count_q == '0);
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign deq_data  = mem[rd_ptr];

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;
    assign write_en = enq_fire && !flush && !reset;

    // Storage carries no reset; stale contents are hidden behind deq_valid.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + COUNT_BITS'(1);
                2'b01:   count_q <= count_q - COUNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky drop indicator; flush deliberately leaves it alone so software still sees the loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (!flush && enq_valid && full) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, latency, full/overflow, wrap ordering, flush and reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [7:0] enq_data;
    logic       enq_valid;
    logic       enq_ready;
    logic [7:0] deq_data;
    logic       deq_valid;
    logic       deq_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_data  (enq_data),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .deq_data  (deq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; inputs are changed and outputs sampled 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    task automatic enq_one(input logic [7:0] d);
        enq_data = d; enq_valid = 1'b1;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else n_pass++;
        n_total++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready got %b exp 1", enq_ready); else n_pass++;
        n_total++; if (deq_valid !== 1'b0) $display("FAIL reset_deq_valid got %b exp 0", deq_valid); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
    endtask

    task automatic test_single();
        enq_data = 8'h41; enq_valid = 1'b1;
        n_total++; if (deq_valid !== 1'b0) $display("FAIL single_no_bypass got %b exp 0", deq_valid); else n_pass++;
        tick();
        enq_valid = 1'b0;
        n_total++; if (deq_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", deq_valid); else n_pass++;
        n_total++; if (deq_data !== 8'h41) $display("FAIL single_data got %h exp 41", deq_data); else n_pass++;
        n_total++; if (count !== 5'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_total++; if (deq_valid !== 1'b1 || deq_data !== 8'h41)
            $display("FAIL single_hold got valid=%b data=%h exp valid=1 data=41", deq_valid, deq_data); else n_pass++;
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        n_total++; if (empty !== 1'b1) $display("FAIL single_drained_empty got %b exp 1", empty); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL single_drained_count got %0d exp 0", count); else n_pass++;
        // Empty FIFO ignores deq_ready: no underflow.
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        n_total++; if (count !== 5'd0 || empty !== 1'b1)
            $display("FAIL underflow got count=%0d empty=%b exp count=0 empty=1", count, empty); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) enq_one(8'(i));
        n_total++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else n_pass++;
        n_total++; if (enq_ready !== 1'b0) $display("FAIL fill_enq_ready got %b exp 0", enq_ready); else n_pass++;
        n_total++; if (count !== 5'd16) $display("FAIL fill_count got %0d exp 16", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL fill_no_overflow got %b exp 0", overflow); else n_pass++;
        enq_one(8'hAA);
        n_total++; if (overflow !== 1'b1) $display("FAIL fill_overflow got %b exp 1", overflow); else n_pass++;
        n_total++; if (count !== 5'd16) $display("FAIL fill_count_after_drop got %0d exp 16", count); else n_pass++;
        deq_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_total++; if (deq_valid !== 1'b1 || deq_data !== 8'(i))
                $display("FAIL drain_data[%0d] got valid=%b data=%h exp valid=1 data=%h", i, deq_valid, deq_data, 8'(i));
            else n_pass++;
            tick();
        end
        deq_ready = 1'b0;
        n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL drain_overflow_sticky got %b exp 1", overflow); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] next_byte = 8'h10;
        int received = 0;
        int cycles = 0;
        while ((next_byte != 8'h38 || q.size() != 0) && cycles < 500) begin
            enq_valid = (next_byte != 8'h38) && (q.size() < 15);
            enq_data  = next_byte;
            deq_ready = ((q.size() > 1) || (next_byte == 8'h38)) ? 1'($urandom_range(0, 1)) : 1'b0;
            n_total++; if (deq_valid !== (q.size() != 0))
                $display("FAIL wrap_valid got %b exp %b", deq_valid, q.size() != 0); else n_pass++;
            if (deq_ready && q.size() != 0) begin
                n_total++; if (deq_data !== q[0])
                    $display("FAIL wrap_data got %h exp %h", deq_data, q[0]); else n_pass++;
                void'(q.pop_front());
                received++;
            end
            if (enq_valid) begin
                q.push_back(next_byte);
                next_byte++;
            end
            tick();
            cycles++;
            n_total++; if (count !== 5'(q.size()))
                $display("FAIL wrap_count got %0d exp %0d", count, q.size()); else n_pass++;
        end
        enq_valid = 1'b0; deq_ready = 1'b0;
        n_total++; if (received != 40) $display("FAIL wrap_received got %0d exp 40", received); else n_pass++;
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 16; i++) enq_one(8'h50 + 8'(i));
        enq_data = 8'hEE; enq_valid = 1'b1; deq_ready = 1'b1;
        n_total++; if (enq_ready !== 1'b0) $display("FAIL simul_enq_ready got %b exp 0", enq_ready); else n_pass++;
        tick();
        enq_valid = 1'b0; deq_ready = 1'b0;
        n_total++; if (count !== 5'd15) $display("FAIL simul_count got %0d exp 15", count); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL simul_overflow got %b exp 1", overflow); else n_pass++;
        enq_one(8'hEF);
        n_total++; if (count !== 5'd16) $display("FAIL simul_refill_count got %0d exp 16", count); else n_pass++;
        deq_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_d;
            exp_d = (i < 15) ? 8'h51 + 8'(i) : 8'hEF;
            n_total++; if (deq_data !== exp_d)
                $display("FAIL simul_drain[%0d] got %h exp %h", i, deq_data, exp_d); else n_pass++;
            tick();
        end
        deq_ready = 1'b0;
        n_total++; if (empty !== 1'b1) $display("FAIL simul_empty got %b exp 1", empty); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) enq_one(8'h60 + 8'(i));
        flush = 1'b1; enq_valid = 1'b1; enq_data = 8'h99; deq_ready = 1'b1;
        tick();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        n_total++; if (count !== 5'd0) $display("FAIL flush_count got %0d exp 0", count); else n_pass++;
        n_total++; if (empty !== 1'b1 || deq_valid !== 1'b0)
            $display("FAIL flush_empty got empty=%b valid=%b exp 1/0", empty, deq_valid); else n_pass++;
        enq_one(8'h70);
        n_total++; if (deq_data !== 8'h70 || count !== 5'd1)
            $display("FAIL flush_restart got data=%h count=%0d exp 70/1", deq_data, count); else n_pass++;
        // Flush must not clear a pending overflow.
        for (int i = 0; i < 15; i++) enq_one(8'h80 + 8'(i));
        enq_one(8'hAB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_total++; if (overflow !== 1'b1 || count !== 5'd0)
            $display("FAIL flush_keeps_overflow got ovf=%b count=%0d exp 1/0", overflow, count); else n_pass++;
        for (int i = 0; i < 3; i++) enq_one(8'hC0 + 8'(i));
        reset = 1'b1; enq_valid = 1'b1; enq_data = 8'hDD;
        tick();
        reset = 1'b0; enq_valid = 1'b0;
        n_total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || enq_ready !== 1'b1 || deq_valid !== 1'b0)
            $display("FAIL midreset_state got count=%0d empty=%b full=%b rdy=%b valid=%b exp 0/1/0/1/0",
                     count, empty, full, enq_ready, deq_valid);
        else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL midreset_overflow got %b exp 0", overflow); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = 8'h00;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_full_simul();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
